// File: rtl/tk_pkg.sv
//------------------------------------------------------------------------------
// tk_pkg
// Shared types and constants for the timekeeper mode controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tk_pkg;

  // Field widths of the hour / minute / second buses
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  // Mode codes presented on the mode output
  localparam logic [1:0] MODE_CLOCK = 2'd0;
  localparam logic [1:0] MODE_SW    = 2'd1;
  localparam logic [1:0] MODE_TMR   = 2'd2;

  // Controller states
  typedef enum logic [2:0] {
    ST_CLOCK     = 3'd0,
    ST_CLOCK_SET = 3'd1,
    ST_STOPWATCH = 3'd2,
    ST_TIMER     = 3'd3,
    ST_TIMER_SET = 3'd4
  } state_t;

  // Map a state onto the function whose value is displayed
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_STOPWATCH:             mode_of = MODE_SW;
      ST_TIMER, ST_TIMER_SET:   mode_of = MODE_TMR;
      default:                  mode_of = MODE_CLOCK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/timekeeper_mode_ctrl_tick_prescaler.sv
//------------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-cycle 1 Hz enable and a 50% blink
// phase derived from the same counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_1hz,
  output logic blink
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_HZ / 2);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // Free-running 0..CLK_HZ-1 counter; the tick follows the terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == C_TERM) ? '0 : cnt_q + CNT_W'(1);
      tick_q <= (cnt_q == C_TERM);
    end
  end

  assign tick_1hz = tick_q;
  assign blink    = (cnt_q >= C_HALF);

endmodule

`default_nettype wire

// File: rtl/timekeeper_mode_ctrl.sv
//------------------------------------------------------------------------------
// timekeeper_mode_ctrl
// Mode controller for the clock / stopwatch / countdown timer: owns the mode
// state machine, routes set-mode increment pulses, muxes the display and
// raises a timed alert when the countdown expires.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timekeeper_mode_ctrl
  import tk_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int ALERT_SECS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              set_btn,
  input  logic              hour_btn,
  input  logic              min_btn,
  input  logic              sec_btn,
  input  logic [HOUR_W-1:0] clk_hour,
  input  logic [MIN_W-1:0]  clk_min,
  input  logic [SEC_W-1:0]  clk_sec,
  input  logic [HOUR_W-1:0] sw_hour,
  input  logic [MIN_W-1:0]  sw_min,
  input  logic [SEC_W-1:0]  sw_sec,
  input  logic [HOUR_W-1:0] tmr_hour,
  input  logic [MIN_W-1:0]  tmr_min,
  input  logic [SEC_W-1:0]  tmr_sec,
  input  logic              tmr_done,
  output logic              tick_1hz,
  output logic [1:0]        mode,
  output logic              set_active,
  output logic              clk_hold,
  output logic              sw_active,
  output logic              clk_hour_inc,
  output logic              clk_min_inc,
  output logic              clk_sec_inc,
  output logic              tmr_hour_inc,
  output logic              tmr_min_inc,
  output logic              tmr_sec_inc,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic [SEC_W-1:0]  disp_sec,
  output logic              disp_blank,
  output logic              alert
);

  localparam int ACNT_W = $clog2(ALERT_SECS + 1);

  logic              tick_w;
  logic              blink_w;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic              set_active_q, clk_hold_q, sw_active_q;
  logic [2:0]        clk_inc_q, clk_inc_d;
  logic [2:0]        tmr_inc_q, tmr_inc_d;
  logic [HOUR_W-1:0] disp_hour_q, disp_hour_d;
  logic [MIN_W-1:0]  disp_min_q, disp_min_d;
  logic [SEC_W-1:0]  disp_sec_q, disp_sec_d;
  logic              disp_blank_q;
  logic              alert_q, alert_d;
  logic [ACNT_W-1:0] alert_cnt_q, alert_cnt_d;
  logic              tmr_done_q;

  logic              tmr_rise;
  logic              any_btn;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_w),
    .blink    (blink_w)
  );

  assign tmr_rise = tmr_done & ~tmr_done_q;
  assign any_btn  = mode_btn | set_btn | hour_btn | min_btn | sec_btn;

  // Next state and alert: expiry beats everything, then alert acknowledge,
  // then ordinary button navigation
  always_comb begin
    state_d     = state_q;
    alert_d     = alert_q;
    alert_cnt_d = alert_cnt_q;
    if (tmr_rise) begin
      alert_d     = 1'b1;
      alert_cnt_d = ACNT_W'(ALERT_SECS);
      // Setting the clock is never interrupted by a timer expiry
      if (state_q != ST_CLOCK_SET) state_d = ST_TIMER;
    end else if (alert_q) begin
      if (any_btn) begin
        alert_d = 1'b0;
      end else if (tick_w) begin
        alert_cnt_d = alert_cnt_q - ACNT_W'(1);
        if (alert_cnt_q == ACNT_W'(1)) alert_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_CLOCK: begin
          if (mode_btn)     state_d = ST_STOPWATCH;
          else if (set_btn) state_d = ST_CLOCK_SET;
        end
        ST_STOPWATCH: begin
          if (mode_btn)     state_d = ST_TIMER;
        end
        ST_TIMER: begin
          if (mode_btn)     state_d = ST_CLOCK;
          else if (set_btn) state_d = ST_TIMER_SET;
        end
        ST_CLOCK_SET: begin
          if (set_btn)      state_d = ST_CLOCK;
        end
        ST_TIMER_SET: begin
          if (set_btn)      state_d = ST_TIMER;
        end
        default:            state_d = ST_CLOCK;
      endcase
    end
  end

  // Increment routing and display selection from the current state
  always_comb begin
    clk_inc_d   = '0;
    tmr_inc_d   = '0;
    disp_hour_d = clk_hour;
    disp_min_d  = clk_min;
    disp_sec_d  = clk_sec;
    if (!alert_q && state_q == ST_CLOCK_SET) clk_inc_d = {hour_btn, min_btn, sec_btn};
    if (!alert_q && state_q == ST_TIMER_SET) tmr_inc_d = {hour_btn, min_btn, sec_btn};
    case (state_q)
      ST_STOPWATCH: begin
        disp_hour_d = sw_hour;
        disp_min_d  = sw_min;
        disp_sec_d  = sw_sec;
      end
      ST_TIMER, ST_TIMER_SET: begin
        disp_hour_d = tmr_hour;
        disp_min_d  = tmr_min;
        disp_sec_d  = tmr_sec;
      end
      default: begin
        disp_hour_d = clk_hour;
        disp_min_d  = clk_min;
        disp_sec_d  = clk_sec;
      end
    endcase
  end

  // State, decoded outputs (taken from the next state), pulses and display
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLOCK;
      mode_q       <= MODE_CLOCK;
      set_active_q <= 1'b0;
      clk_hold_q   <= 1'b0;
      sw_active_q  <= 1'b0;
      clk_inc_q    <= '0;
      tmr_inc_q    <= '0;
      disp_hour_q  <= '0;
      disp_min_q   <= '0;
      disp_sec_q   <= '0;
      disp_blank_q <= 1'b0;
      alert_q      <= 1'b0;
      alert_cnt_q  <= '0;
      tmr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_of(state_d);
      set_active_q <= (state_d == ST_CLOCK_SET) || (state_d == ST_TIMER_SET);
      clk_hold_q   <= (state_d == ST_CLOCK_SET);
      sw_active_q  <= (state_d == ST_STOPWATCH);
      clk_inc_q    <= clk_inc_d;
      tmr_inc_q    <= tmr_inc_d;
      disp_hour_q  <= disp_hour_d;
      disp_min_q   <= disp_min_d;
      disp_sec_q   <= disp_sec_d;
      disp_blank_q <= set_active_q & blink_w;
      alert_q      <= alert_d;
      alert_cnt_q  <= alert_cnt_d;
      tmr_done_q   <= tmr_done;
    end
  end

  assign tick_1hz     = tick_w;
  assign mode         = mode_q;
  assign set_active   = set_active_q;
  assign clk_hold     = clk_hold_q;
  assign sw_active    = sw_active_q;
  assign clk_hour_inc = clk_inc_q[2];
  assign clk_min_inc  = clk_inc_q[1];
  assign clk_sec_inc  = clk_inc_q[0];
  assign tmr_hour_inc = tmr_inc_q[2];
  assign tmr_min_inc  = tmr_inc_q[1];
  assign tmr_sec_inc  = tmr_inc_q[0];
  assign disp_hour    = disp_hour_q;
  assign disp_min     = disp_min_q;
  assign disp_sec     = disp_sec_q;
  assign disp_blank   = disp_blank_q;
  assign alert        = alert_q;

endmodule

`default_nettype wire
